// File: rtl/get_dist_block.sv
// get_dist_block: SSE/SAD distortion between two ROWS x LANES pixel blocks.
// One row is issued per cycle into a four-stage pipeline (difference,
// square/abs, row-sum, accumulate). The accumulator saturates to all-ones
// and raises a sticky overflow flag.
//
// Handshake: start is a request sampled every cycle and accepted only
// while busy is low. busy rises the cycle after acceptance and stays high
// up to and including the single-cycle done pulse. result/ovf are valid
// from done and hold until the edge after the next accepted start.
module get_dist_block #(
  parameter int BIT_WIDTH = 8,
  parameter int LANES     = 16,
  parameter int ROWS      = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            mode,
  input  logic [BIT_WIDTH*LANES*ROWS-1:0] a,
  input  logic [BIT_WIDTH*LANES*ROWS-1:0] b,
  output logic                            busy,
  output logic [ACC_WIDTH-1:0]            result,
  output logic                            ovf,
  output logic                            done,
  output logic [1:0]                      dbg_state_o
);

  localparam int ROW_W  = BIT_WIDTH * LANES;
  localparam int RCW    = $clog2(ROWS);
  localparam int SQ_W   = 2 * BIT_WIDTH;
  localparam int SUM_W  = SQ_W + $clog2(LANES);
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [RCW-1:0]          row_q;
  logic                    mode_q;
  logic                    accept;
  logic                    issue;

  // Pipeline stage registers and their valid/last-row tags
  logic                    v1_q, v2_q, v3_q;
  logic                    last1_q, last2_q, last3_q;
  logic signed [BIT_WIDTH:0] d1_q [LANES];
  logic [SQ_W-1:0]         p2_q [LANES];
  logic [SUM_W-1:0]        s3_q;

  logic [ACC_WIDTH-1:0]    result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;

  // Combinational stage values
  logic [ROW_W-1:0]        a_row_c, b_row_c;
  logic signed [BIT_WIDTH:0] diff_c [LANES];
  logic [SQ_W-1:0]         dext_c [LANES];
  logic [BIT_WIDTH:0]      mag_c  [LANES];
  logic [SQ_W-1:0]         val_c  [LANES];
  logic [SUM_W-1:0]        row_sum_c;
  logic [ACC_WIDTH:0]      acc_sum_c;

  assign accept      = start && (state_q == ST_IDLE);
  assign issue       = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_q;
  assign ovf         = ovf_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Control FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Control FSM next state: issue ROWS rows, then drain until done fires
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (row_q == LAST_ROW) state_d = ST_DRAIN;
      ST_DRAIN: if (done_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Row counter and latched mode; the counter stops at the last row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      row_q  <= '0;
      mode_q <= mode;
    end else if (issue && (row_q != LAST_ROW)) begin
      row_q  <= row_q + RCW'(1);
    end
  end

  // S1 inputs: select the issued row and form signed per-lane differences
  always_comb begin
    a_row_c = a[row_q*ROW_W +: ROW_W];
    b_row_c = b[row_q*ROW_W +: ROW_W];
    for (int l = 0; l < LANES; l++) begin
      diff_c[l] = $signed({1'b0, a_row_c[l*BIT_WIDTH +: BIT_WIDTH]})
                - $signed({1'b0, b_row_c[l*BIT_WIDTH +: BIT_WIDTH]});
    end
  end

  // S2 inputs: square (low 2*BIT_WIDTH bits hold the exact square) or |diff|
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      dext_c[l] = {{(BIT_WIDTH-1){d1_q[l][BIT_WIDTH]}}, d1_q[l]};
      mag_c[l]  = d1_q[l][BIT_WIDTH] ? -d1_q[l] : d1_q[l];
      val_c[l]  = mode_q ? {{(BIT_WIDTH-1){1'b0}}, mag_c[l]}
                         : dext_c[l] * dext_c[l];
    end
  end

  // S3 inputs: full-width row sum across lanes
  always_comb begin
    row_sum_c = '0;
    for (int l = 0; l < LANES; l++) begin
      row_sum_c = row_sum_c + SUM_W'(p2_q[l]);
    end
  end

  // Pipeline registers S1..S3 with valid and last-row tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      s3_q    <= '0;
      for (int l = 0; l < LANES; l++) begin
        d1_q[l] <= '0;
        p2_q[l] <= '0;
      end
    end else begin
      v1_q    <= issue;
      last1_q <= issue && (row_q == LAST_ROW);
      v2_q    <= v1_q;
      last2_q <= last1_q;
      v3_q    <= v2_q;
      last3_q <= last2_q;
      s3_q    <= row_sum_c;
      for (int l = 0; l < LANES; l++) begin
        d1_q[l] <= diff_c[l];
        p2_q[l] <= val_c[l];
      end
    end
  end

  // S4: saturating accumulate, cleared on accept, frozen once saturated
  always_comb begin
    acc_sum_c = {1'b0, result_q} + (ACC_WIDTH+1)'(s3_q);
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_d    = v3_q && last3_q;
    if (accept) begin
      result_d = '0;
      ovf_d    = 1'b0;
    end else if (v3_q && !ovf_q) begin
      if (acc_sum_c[ACC_WIDTH]) begin
        result_d = '1;
        ovf_d    = 1'b1;
      end else begin
        result_d = acc_sum_c[ACC_WIDTH-1:0];
      end
    end
  end

  // Accumulator, overflow flag and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_get_dist_block.sv
// Directed testbench for get_dist_block: default instance (ACC_WIDTH=32)
// plus a narrow-accumulator instance (ACC_WIDTH=20) sharing all inputs.
module tb_get_dist_block;

  localparam int BW     = 8;
  localparam int LANES  = 16;
  localparam int ROWS   = 8;
  localparam int DATA_W = BW * LANES * ROWS;
  localparam int DONE_C = ROWS + 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode  = 1'b0;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;

  logic        busy, ovf, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;
  logic        s_busy, s_ovf, s_done;
  logic [19:0] s_result;
  logic [1:0]  s_dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Observations collected by the driver
  int          done_at, done_cnt, s_done_cnt;
  bit          busy_ok;
  logic [31:0] res_done;
  logic        ovf_done;
  logic [19:0] s_res_done;
  logic        s_ovf_done;

  get_dist_block dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .result(result), .ovf(ovf), .done(done),
    .dbg_state_o(dbg_state)
  );

  get_dist_block #(.ACC_WIDTH(20)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(s_busy), .result(s_result), .ovf(s_ovf), .done(s_done),
    .dbg_state_o(s_dbg_state)
  );

  // Watchdog: every wait is cycle-bounded, this only guards against a stall
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: uniform pixel values for a and b
  task automatic fill(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < LANES * ROWS; i++) begin
      a[i*BW +: BW] = av;
      b[i*BW +: BW] = bv;
    end
  endtask

  // Driver: row r of a = r in every lane, b = 0
  task automatic fill_rows();
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < LANES; l++) begin
        a[(r*LANES+l)*BW +: BW] = 8'(r);
        b[(r*LANES+l)*BW +: BW] = 8'd0;
      end
    end
  endtask

  // Driver: accept in cycle 0, watch cycles 1..ROWS+10; optional mode toggle
  // and extra start pulses at given cycles (-1 = none)
  task automatic run_op(input logic m, input int toggle_cyc,
                        input int extra1, input int extra2);
    done_at = -1; done_cnt = 0; s_done_cnt = 0; busy_ok = 1'b1;
    res_done = '0; ovf_done = 1'b0; s_res_done = '0; s_ovf_done = 1'b0;
    @(posedge clk); #1;
    if (busy !== 1'b0) busy_ok = 1'b0;
    mode  = m;
    start = 1'b1;
    for (int cyc = 1; cyc <= ROWS + 10; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == extra1) || (cyc == extra2);
      if (cyc == toggle_cyc) mode = ~m;
      if (busy !== (cyc <= DONE_C)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++; done_at = cyc; res_done = result; ovf_done = ovf;
      end
      if (s_done === 1'b1) begin
        s_done_cnt++; s_res_done = s_result; s_ovf_done = s_ovf;
      end
    end
    start = 1'b0;
    mode  = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %0b want 0", done); end
    vec_cnt++; if (result !== 32'd0) begin err_cnt++; $display("FAIL reset_result: got %0d want 0", result); end
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    fill(8'd0, 8'd0);
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    vec_cnt++; if (done_at !== DONE_C) begin err_cnt++; $display("FAIL zero_done_cycle: got %0d want %0d", done_at, DONE_C); end
    vec_cnt++; if (busy_ok !== 1'b1) begin err_cnt++; $display("FAIL zero_busy_window: got %0b want 1", busy_ok); end
    vec_cnt++; if (res_done !== 32'd0) begin err_cnt++; $display("FAIL zero_result: got %0d want 0", res_done); end
    vec_cnt++; if (ovf_done !== 1'b0) begin err_cnt++; $display("FAIL zero_ovf: got %0b want 0", ovf_done); end
  endtask

  task automatic test_sse_sad();
    fill(8'd10, 8'd7);
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd1152) begin err_cnt++; $display("FAIL sse_10_7: got %0d want 1152", res_done); end
    vec_cnt++; if (done_at !== DONE_C) begin err_cnt++; $display("FAIL sse_10_7_cycle: got %0d want %0d", done_at, DONE_C); end
    run_op(1'b1, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd384) begin err_cnt++; $display("FAIL sad_10_7: got %0d want 384", res_done); end
    vec_cnt++; if (result !== 32'd384) begin err_cnt++; $display("FAIL sad_10_7_hold: got %0d want 384", result); end
    run_op(1'b1, 3, -1, -1);
    vec_cnt++; if (res_done !== 32'd384) begin err_cnt++; $display("FAIL sad_mode_toggle: got %0d want 384", res_done); end
    run_op(1'b0, 2, -1, -1);
    vec_cnt++; if (res_done !== 32'd1152) begin err_cnt++; $display("FAIL sse_mode_toggle: got %0d want 1152", res_done); end
  endtask

  task automatic test_extremes();
    fill(8'd0, 8'd255);
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd8323200) begin err_cnt++; $display("FAIL sse_0_255: got %0d want 8323200", res_done); end
    vec_cnt++; if (ovf_done !== 1'b0) begin err_cnt++; $display("FAIL sse_0_255_ovf: got %0b want 0", ovf_done); end
    run_op(1'b1, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd32640) begin err_cnt++; $display("FAIL sad_0_255: got %0d want 32640", res_done); end
    fill(8'd255, 8'd0);
    run_op(1'b1, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd32640) begin err_cnt++; $display("FAIL sad_255_0: got %0d want 32640", res_done); end
  endtask

  task automatic test_rows();
    fill_rows();
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd2240) begin err_cnt++; $display("FAIL rows_sse: got %0d want 2240", res_done); end
    run_op(1'b1, -1, -1, -1);
    vec_cnt++; if (res_done !== 32'd448) begin err_cnt++; $display("FAIL rows_sad: got %0d want 448", res_done); end
  endtask

  task automatic test_saturation();
    fill(8'd255, 8'd0);
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (s_done_cnt !== 1) begin err_cnt++; $display("FAIL sat_done_count: got %0d want 1", s_done_cnt); end
    vec_cnt++; if (s_res_done !== 20'hFFFFF) begin err_cnt++; $display("FAIL sat_result: got %0h want fffff", s_res_done); end
    vec_cnt++; if (s_ovf_done !== 1'b1) begin err_cnt++; $display("FAIL sat_ovf: got %0b want 1", s_ovf_done); end
    vec_cnt++; if (s_ovf !== 1'b1) begin err_cnt++; $display("FAIL sat_ovf_sticky: got %0b want 1", s_ovf); end
    vec_cnt++; if (res_done !== 32'd8323200) begin err_cnt++; $display("FAIL wide_no_sat: got %0d want 8323200", res_done); end
    fill(8'd0, 8'd0);
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (s_res_done !== 20'd0) begin err_cnt++; $display("FAIL sat_clear_result: got %0h want 0", s_res_done); end
    vec_cnt++; if (s_ovf_done !== 1'b0) begin err_cnt++; $display("FAIL sat_clear_ovf: got %0b want 0", s_ovf_done); end
  endtask

  task automatic test_ignored_start();
    fill(8'd10, 8'd7);
    run_op(1'b0, -1, 3, DONE_C);
    vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    vec_cnt++; if (done_at !== DONE_C) begin err_cnt++; $display("FAIL ignore_done_cycle: got %0d want %0d", done_at, DONE_C); end
    vec_cnt++; if (busy_ok !== 1'b1) begin err_cnt++; $display("FAIL ignore_busy_window: got %0b want 1", busy_ok); end
    vec_cnt++; if (res_done !== 32'd1152) begin err_cnt++; $display("FAIL ignore_result: got %0d want 1152", res_done); end
  endtask

  task automatic test_abort();
    int  late_done;
    bit  late_busy;
    fill(8'd10, 8'd7);
    @(posedge clk); #1;
    mode  = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL abort_busy_before: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %0b want 0", busy); end
    vec_cnt++; if (result !== 32'd0) begin err_cnt++; $display("FAIL abort_result: got %0d want 0", result); end
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL abort_ovf: got %0b want 0", ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    late_done = 0;
    late_busy = 1'b0;
    for (int cyc = 0; cyc < ROWS + 10; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) late_done++;
      if (busy !== 1'b0) late_busy = 1'b1;
    end
    vec_cnt++; if (late_done !== 0) begin err_cnt++; $display("FAIL abort_no_done: got %0d want 0", late_done); end
    vec_cnt++; if (late_busy !== 1'b0) begin err_cnt++; $display("FAIL abort_stays_idle: got %0b want 0", late_busy); end
    run_op(1'b0, -1, -1, -1);
    vec_cnt++; if (done_at !== DONE_C) begin err_cnt++; $display("FAIL abort_rerun_cycle: got %0d want %0d", done_at, DONE_C); end
    vec_cnt++; if (res_done !== 32'd1152) begin err_cnt++; $display("FAIL abort_rerun_result: got %0d want 1152", res_done); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sse_sad();
    test_extremes();
    test_rows();
    test_saturation();
    test_ignored_start();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
